// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. It takes a byte stream over a
//   valid/ready handshake and packs every three bytes (big-endian) into one
//   WORD_W-bit instruction word. Each word goes to the RAM write port at a
//   word-aligned byte address (0, 4, 8, ...). The CPU is held in reset for
//   the whole load.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
//   in_ready is decoded from registered state only, so it never depends on
//   in_valid. The producer may hold or drop in_valid freely. The loader holds
//   its state until a byte transfers.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             load request, honoured only while idle
//   word_count        words to load, clamped to DEPTH, latched with start
//   in_valid/in_data  byte stream in
//   in_ready          loader accepts a byte this cycle
//   we/waddr/wdata    RAM write port, one-cycle we pulse per word
//   busy, cpu_hold    load in progress (cpu_hold mirrors busy)
//   done              one-cycle pulse when a load finishes
//   err               sticky: count clamped or nonzero padding bits seen
//   dbg_state         current FSM state, for observation only
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int WORD_W = 18,
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Counter width large enough to hold DEPTH itself.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_B0    = 3'd1;
  localparam logic [2:0] S_B1    = 3'd2;
  localparam logic [2:0] S_B2    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] word_q,  word_d;
  logic [CW-1:0]     idx_q,   idx_d;
  logic [CW-1:0]     eff_q,   eff_d;
  logic              err_q,   err_d;

  logic xfer;

  assign in_ready = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    eff_d   = eff_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (word_count > DEPTH_A) begin
            eff_d = DEPTH_C;
            err_d = 1'b1;
          end else begin
            eff_d = word_count[CW-1:0];
            err_d = 1'b0;
          end
          // A zero count skips the byte phases entirely.
          state_d = (word_count == '0) ? S_DONE : S_B0;
        end
      end
      S_B0: begin
        if (xfer) begin
          // Only the low two bits carry data. The rest is padding that
          // must be zero. Nonzero padding is flagged but dropped.
          word_d[WORD_W-1:WORD_W-2] = in_data[1:0];
          if (in_data[7:2] != 6'd0) err_d = 1'b1;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (xfer) begin
          word_d[15:8] = in_data;
          state_d      = S_B2;
        end
      end
      S_B2: begin
        if (xfer) begin
          word_d[7:0] = in_data;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx_q + CW'(1) == eff_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + CW'(1);
          state_d = S_B0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      eff_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      eff_q   <= eff_d;
      err_q   <= err_d;
    end
  end

  // The write port is zero outside the WRITE cycle, so the RAM side sees a
  // quiet bus between words.
  assign we        = (state_q == S_WRITE);
  assign waddr     = we ? {{(ADDR_W-CW-2){1'b0}}, idx_q, 2'b00} : '0;
  assign wdata     = we ? word_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign cpu_hold  = busy;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles each group of three bytes into one 18-bit instruction word. It writes each word into the instruction RAM write port at word-aligned byte addresses (0, 4, 8, …), matching the read side's `a[17:2]` indexing. It holds the CPU in reset while a load is in progress and sits between the host/serial front end and the instruction RAM.

## Interface
- `WORD_W`, 18, instruction word width
- `ADDR_W`, 18, byte address width of the instruction memory
- `DEPTH`, 101, number of words in the instruction RAM
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  load request; sampled only in IDLE
- `word_count`  in  ADDR_W  number of words to load; sampled on an accepted `start`
- `in_valid`  in  1  byte available on `in_data`
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept a byte this cycle
- `we`  out  1  RAM write enable, one-cycle pulse per word
- `waddr`  out  ADDR_W  byte address of the write, always a multiple of 4
- `wdata`  out  WORD_W  assembled instruction word
- `busy`  out  1  load in progress
- `cpu_hold`  out  1  keeps the CPU in reset; equal to `busy`
- `done`  out  1  one-cycle pulse at the end of a load
- `err`  out  1  sticky: count clamped, or nonzero padding bits received

## Operation
- States: IDLE, B0, B1, B2, WRITE, DONE.
- IDLE:
  - On `start`, latch `eff_count = min(word_count, DEPTH)` and clear `word_idx` and `err`.
  - Set `err` if `word_count > DEPTH`.
  - Go to DONE if `eff_count == 0`; otherwise go to B0.
- B0, B1, B2:
  - `in_ready = 1`. A byte transfers only on a cycle with `in_valid && in_ready`.
  - If no byte transfers, the FSM holds its state.
- Byte order is big-endian:
  - B0 byte: `in_data[1:0]` → `word[17:16]`. `in_data[7:2]` must be 0; if not, set `err`. The word is still written, with those bits dropped.
  - B1 byte → `word[15:8]`.
  - B2 byte → `word[7:0]`, then go to WRITE.
- WRITE (one cycle):
  - `we = 1`, `waddr = word_idx << 2`, `wdata = word`. `in_ready = 0`.
  - If `word_idx + 1 == eff_count`, go to DONE; otherwise increment `word_idx` and go to B0.
- DONE (one cycle): `done = 1`, then go to IDLE.
- `busy = 1` in every state except IDLE.
- `start` is ignored outside IDLE.
- `err` holds its value until the next accepted `start` or reset.
- The `word_idx` counter is wide enough for `DEPTH`. `waddr` is zero-extended to `ADDR_W`; bits [1:0] are always 0.
- Bytes offered while in IDLE, WRITE or DONE are not consumed (`in_ready = 0`).

## Timing
- Reset (`rst_n = 0` at a rising edge):
  - State goes to IDLE.
  - `in_ready`, `we`, `busy`, `cpu_hold`, `done` and `err` are 0. `waddr` and `wdata` are 0.
  - The assembly register and `word_idx` are cleared.
- Reset mid-load aborts the load: no further writes, no `done`. Words already written stay in the RAM.
- Outputs are registered or decoded from registered state only; there is no combinational path from `in_valid` to `in_ready`.
- `start` accepted in cycle t → `busy = 1` from t+1. `in_ready = 1` from t+1, unless `eff_count == 0`.
- Third byte accepted in cycle t → `we = 1` during t+1.
- With `in_valid` held high, each word takes 4 cycles (3 bytes + WRITE).
- Last word's `we` in cycle t → `done = 1` in t+1 → `busy = 0` from t+2.
- `eff_count == 0`: `start` in t → `done` in t+1, no `we`.
- Throughput with `in_valid` continuously high: N words complete in 4N + 2 cycles from `start` to `busy` low.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_n = 0` for 3 cycles, release.
  - Required: all outputs are 0; `in_ready = 0` until `start`.
- Two-word load, streaming:
  - Stimulus: `word_count = 2`; bytes 0x00,0xFB,0xA0 then 0x01,0x03,0xAD.
  - Required: `we` at address 0 with `wdata = 18'h0FBA0`, then at address 4 with `wdata = 18'h103AD`.
  - Required: `done` one cycle after the second `we`; `err = 0`; total 10 cycles from `start` to `busy` low.
- Bubbles:
  - Stimulus: same data, `in_valid` toggled every other cycle.
  - Required: identical writes; FSM holds in B0/B1/B2 while `in_valid = 0`; no extra `we`.
- Padding error and clamp:
  - Stimulus: first byte 0xFF.
  - Required: `err = 1` and `wdata[17:16] = 2'b11`.
  - Stimulus: `word_count = 200`.
  - Required: exactly 101 writes with last `waddr = 400`; `err = 1`.
- Edge cases:
  - Stimulus: `word_count = 0`.
  - Required: `done` the cycle after `start`, no `we`.
  - Stimulus: `start` asserted mid-load.
  - Required: ignored.
- Mid-load reset:
  - Stimulus: `rst_n` low after the B1 byte of word 1.
  - Required: no `we` for that word, no `done`; IDLE with all outputs 0 afterward. A new `start` restarts at address 0.
